// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcode and ALU-op encodings shared by the decode stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Opcodes that read rt as a source operand; only these can hit a load-use hazard on rt.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_decoder.sv
// ============================================================================
// control_decoder : combinational opcode-to-control mapping for decode_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_decoder
  import mips_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] dest,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_op,
  output logic       illegal
);

  always_comb begin
    dest       = 5'd0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          dest      = rd;
          reg_write = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          dest       = rt;
          reg_write  = 1'b1;
          mem_read   = 1'b1;
          alu_src    = 1'b1;
          mem_to_reg = 1'b1;
        end
        OP_SW: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BEQ: begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
        OP_ADDI: begin
          dest      = rt;
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_J:    jump = 1'b1;
        default: illegal = 1'b1;
      endcase
      // Writes to $zero are architecturally discarded.
      if (dest == 5'd0) reg_write = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : MIPS IF/ID register with valid/ready handshake and
//                load-use hazard stall.  Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_ready,
  output logic [4:0]  rf_rs,
  output logic [4:0]  rf_rt,
  output logic        id_out_valid,
  output logic [4:0]  id_dest,
  output logic [31:0] id_imm,
  output logic [31:0] id_pc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic        illegal
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  opcode;
  logic        hazard;
  logic        capture;
  logic        transfer;

  assign opcode = instr_q[31:26];
  assign rf_rs  = instr_q[25:21];
  assign rf_rt  = instr_q[20:16];
  assign id_imm = {{16{instr_q[15]}}, instr_q[15:0]};
  assign id_pc  = pc_q;

  // Load in EX writes a register the held instruction reads: insert a bubble.
  assign hazard = id_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rf_rs) || ((ex_rt == rf_rt) && reads_rt(opcode)));

  assign id_out_valid = id_valid_q && !hazard;
  assign if_ready     = !id_valid_q || (ex_ready && !hazard);
  assign capture      = if_valid && if_ready && !flush;
  assign transfer     = id_out_valid && ex_ready;

  always_comb begin
    id_valid_d = id_valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (capture) begin
      id_valid_d = 1'b1;
      instr_d    = if_instr;
      pc_d       = if_pc;
    end else if (transfer) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
    end else begin
      id_valid_q <= id_valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  control_decoder u_control_decoder (
    .valid      (id_valid_q),
    .opcode     (opcode),
    .rt         (instr_q[20:16]),
    .rd         (instr_q[15:11]),
    .dest       (id_dest),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .branch     (branch),
    .jump       (jump),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : self-checking bench for decode_stage with a scoreboard
//                   of expected decoded bundles. Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_ready;
  logic [4:0]  rf_rs, rf_rt;
  logic        id_out_valid;
  logic [4:0]  id_dest;
  logic [31:0] id_imm, id_pc;
  logic        reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch, jump;
  logic [1:0]  alu_op;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [9:0]  rsrt;
    logic [4:0]  dest;
    logic        dest_chk;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [9:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_ready(ex_ready), .rf_rs(rf_rs), .rf_rt(rf_rt), .id_out_valid(id_out_valid),
    .id_dest(id_dest), .id_imm(id_imm), .id_pc(id_pc), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {illegal, reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch, jump, alu_op}
  wire [9:0] dut_ctrl = {illegal, reg_write, mem_read, mem_write, alu_src,
                         mem_to_reg, branch, jump, alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [4:0] rt, rd;
    rt         = ins[20:16];
    rd         = ins[15:11];
    e.rsrt     = ins[25:16];
    e.imm      = {{16{ins[15]}}, ins[15:0]};
    e.pc       = pc;
    e.dest     = 5'd0;
    e.dest_chk = 1'b0;
    case (ins[31:26])
      6'h00: begin e.ctrl = {1'b0, rd != 5'd0, 6'b000000, 2'b10}; e.dest = rd; e.dest_chk = 1'b1; end
      6'h23: begin e.ctrl = {1'b0, rt != 5'd0, 6'b101100, 2'b00}; e.dest = rt; e.dest_chk = 1'b1; end
      6'h2B: e.ctrl = 10'b00_011000_00;
      6'h04: e.ctrl = 10'b00_000010_01;
      6'h08: begin e.ctrl = {1'b0, rt != 5'd0, 6'b001000, 2'b00}; e.dest = rt; e.dest_chk = 1'b1; end
      6'h02: e.ctrl = 10'b00_000001_00;
      default: e.ctrl = 10'b10_000000_00;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: mid-cycle, inputs are stable until the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (id_out_valid && ex_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_rsrt", {22'd0, rf_rs, rf_rt}, {22'd0, e.rsrt});
          check("sb_imm", id_imm, e.imm);
          check("sb_pc", id_pc, e.pc);
          check("sb_ctrl", {22'd0, dut_ctrl}, {22'd0, e.ctrl});
          if (e.dest_chk) check("sb_dest", {27'd0, id_dest}, {27'd0, e.dest});
        end
      end else if (flush && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      if (if_valid && if_ready && !flush) sb_q.push_back(model(if_instr, if_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; ex_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, id_out_valid}, 32'd0);
    check("rst_ctrl", {22'd0, dut_ctrl}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);

    // add $3,$1,$2
    offer(32'h00221820, 32'h0000_0104);
    tick();
    if_valid = 1'b0;
    #1;
    check("add_rs", {27'd0, rf_rs}, 32'd1);
    check("add_rt", {27'd0, rf_rt}, 32'd2);
    check("add_dest", {27'd0, id_dest}, 32'd3);
    check("add_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b01_000000_10});
    check("add_out_valid", {31'd0, id_out_valid}, 32'd1);
    tick();

    // lw then addi back to back
    offer(32'h8C850008, 32'h0000_0200);
    tick();
    offer(32'h2001FFFF, 32'h0000_0204);
    #1;
    check("lw_dest", {27'd0, id_dest}, 32'd5);
    check("lw_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b01_101100_00});
    check("lw_imm", id_imm, 32'd8);
    check("lw_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    #1;
    check("addi_imm", id_imm, 32'hFFFF_FFFF);
    check("addi_dest", {27'd0, id_dest}, 32'd1);
    tick();

    // load-use hazard on rs
    offer(32'h00A73020, 32'h0000_0300);
    tick();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    check("haz_if_ready", {31'd0, if_ready}, 32'd0);
    check("haz_out_valid", {31'd0, id_out_valid}, 32'd0);
    tick();
    ex_mem_read = 1'b0;
    #1;
    check("haz_clr_if_ready", {31'd0, if_ready}, 32'd1);
    check("haz_clr_out_valid", {31'd0, id_out_valid}, 32'd1);
    check("haz_clr_dest", {27'd0, id_dest}, 32'd6);
    tick();

    // lw does not read rt, so a match on rt is not a hazard
    offer(32'h8C850000, 32'h0000_0310);
    tick();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd5;
    #1;
    check("nohaz_rt_lw", {31'd0, id_out_valid}, 32'd1);
    tick();
    ex_mem_read = 1'b0;

    // EX backpressure for 3 cycles on sw
    ex_ready = 1'b0;
    offer(32'hAC850004, 32'h0000_0400);
    tick();
    offer(32'h00221820, 32'h0000_0404);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_out_valid", {31'd0, id_out_valid}, 32'd1);
      check("bp_if_ready", {31'd0, if_ready}, 32'd0);
      check("bp_imm", id_imm, 32'd4);
      check("bp_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b00_011000_00});
      tick();
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    #1;
    check("bp_next_dest", {27'd0, id_dest}, 32'd3);
    tick();

    // flush with a simultaneous offer during a hazard stall
    offer(32'h00A73020, 32'h0000_0500);
    tick();
    offer(32'h8C850008, 32'h0000_0504);
    ex_mem_read = 1'b1; ex_rt = 5'd5; flush = 1'b1;
    #1;
    check("fl_stall_ready", {31'd0, if_ready}, 32'd0);
    tick();
    if_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0;
    #1;
    check("fl_out_valid", {31'd0, id_out_valid}, 32'd0);
    check("fl_if_ready", {31'd0, if_ready}, 32'd1);
    tick();

    // remaining opcodes, illegal, and $zero destination
    offer(32'hFC000000, 32'h0000_0600);
    tick();
    offer(32'h10220003, 32'h0000_0604);
    #1;
    check("ill_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b10_000000_00});
    check("ill_out_valid", {31'd0, id_out_valid}, 32'd1);
    tick();
    offer(32'h08000010, 32'h0000_0608);
    #1;
    check("beq_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b00_000010_01});
    tick();
    offer(32'h00220020, 32'h0000_060C);
    #1;
    check("j_ctrl", {22'd0, dut_ctrl}, {22'd0, 10'b00_000001_00});
    tick();
    if_valid = 1'b0;
    #1;
    check("rd0_reg_write", {31'd0, reg_write}, 32'd0);
    tick();

    // asynchronous reset while holding under backpressure
    ex_ready = 1'b0;
    offer(32'h00221820, 32'h0000_0700);
    tick();
    if_valid = 1'b0;
    #1;
    check("hold_pre_rst", {31'd0, id_out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, id_out_valid}, 32'd0);
    check("async_rst_ctrl", {22'd0, dut_ctrl}, 32'd0);
    tick();
    rst_n = 1'b1; ex_ready = 1'b1;
    offer(32'h8C850008, 32'h0000_0800);
    tick();
    if_valid = 1'b0;
    #1;
    check("post_rst_cap", {31'd0, id_out_valid}, 32'd1);
    check("post_rst_dest", {27'd0, id_dest}, 32'd5);
    tick();
    tick();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
